// File: rtl/alu_pkg.sv
// alu_pkg: opcode encodings and flag bit positions shared by alu_pipe_regfile and its bench.
package alu_pkg;
  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_ADC  = 4'h2;
  localparam logic [3:0] OP_SBB  = 4'h3;
  localparam logic [3:0] OP_AND  = 4'h4;
  localparam logic [3:0] OP_OR   = 4'h5;
  localparam logic [3:0] OP_XOR  = 4'h6;
  localparam logic [3:0] OP_NOT  = 4'h7;
  localparam logic [3:0] OP_SHL  = 4'h8;
  localparam logic [3:0] OP_SHR  = 4'h9;
  localparam logic [3:0] OP_INC  = 4'hA;
  localparam logic [3:0] OP_DEC  = 4'hB;
  localparam logic [3:0] OP_CMP  = 4'hC;
  localparam logic [3:0] OP_PASS = 4'hD;
  localparam logic [3:0] OP_MUL  = 4'hE;
  localparam logic [3:0] OP_RSV  = 4'hF;
  localparam int FLAG_Z = 0;
  localparam int FLAG_C = 1;
  localparam int FLAG_N = 2;
  localparam int FLAG_V = 3;
endpackage

// File: rtl/alu_regfile.sv
// alu_regfile: async-reset register array, one write port, registered read port with write bypass.
module alu_regfile #(
  parameter int WIDTH  = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);
  logic [WIDTH-1:0] mem [2**ADDR_W];
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      for (int i = 0; i < 2**ADDR_W; i++) mem[i] <= '0;
      rdata <= '0;
    end else begin
      if (we) mem[waddr] <= wdata;
      rdata <= (we && waddr == raddr) ? wdata : mem[raddr];
    end
endmodule

// File: rtl/alu_pipe_regfile.sv
// alu_pipe_regfile: 2-stage ALU pipeline with registered flags and a write-back register file.
// Define ALU_MUL_EN to make opcode E a multiply; otherwise it behaves as a reserved opcode.
module alu_pipe_regfile
  import alu_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [3:0]        opcode,
  input  logic [WIDTH-1:0]  a,
  input  logic [WIDTH-1:0]  b,
  input  logic              write_en,
  input  logic [ADDR_W-1:0] addr,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              out_valid,
  output logic [WIDTH-1:0]  result,
  output logic [WIDTH-1:0]  mem_out,
  output logic              zero_flag,
  output logic              carry,
  output logic              neg_flag,
  output logic              ovf_flag
);
  localparam logic [WIDTH:0] one = {{WIDTH{1'b0}}, 1'b1};
  logic              s1_valid, s1_we;
  logic [3:0]        s1_op;
  logic [WIDTH-1:0]  s1_a, s1_b;
  logic [ADDR_W-1:0] s1_addr;
  logic [3:0]        flags;
  logic [WIDTH:0]    ae, be, ci, sum;
  logic              rsv, add_op, sub_op, sb, ovf, wb;
`ifdef ALU_MUL_EN
  logic [2*WIDTH-1:0] prod;
  assign prod = {{WIDTH{1'b0}}, s1_a} * {{WIDTH{1'b0}}, s1_b};
`endif
  // sum[WIDTH] is the carry for adds, the borrow for subtracts and the shifted-out bit for shifts
  always_comb begin
    ae = {1'b0, s1_a};
    be = {1'b0, s1_b};
    ci = {{WIDTH{1'b0}}, flags[FLAG_C]};
    sum = '0;
    rsv = 1'b0;
    case (s1_op)
      OP_ADD:         sum = ae + be;
      OP_SUB, OP_CMP: sum = ae - be;
      OP_ADC:         sum = ae + be + ci;
      OP_SBB:         sum = ae - be - ci;
      OP_AND:         sum = ae & be;
      OP_OR:          sum = ae | be;
      OP_XOR:         sum = ae ^ be;
      OP_NOT:         sum = {1'b0, ~s1_a};
      OP_SHL:         sum = {s1_a, 1'b0};
      OP_SHR:         sum = {s1_a[0], 1'b0, s1_a[WIDTH-1:1]};
      OP_INC:         sum = ae + one;
      OP_DEC:         sum = ae - one;
      OP_PASS:        sum = ae;
`ifdef ALU_MUL_EN
      OP_MUL:         sum = {|prod[2*WIDTH-1:WIDTH], prod[WIDTH-1:0]};
`endif
      default:        rsv = 1'b1;
    endcase
  end
  assign add_op = s1_op inside {OP_ADD, OP_ADC, OP_INC};
  assign sub_op = s1_op inside {OP_SUB, OP_SBB, OP_CMP, OP_DEC};
  assign sb = (s1_op == OP_INC || s1_op == OP_DEC) ? 1'b0 : s1_b[WIDTH-1];
  assign ovf = (sum[WIDTH-1] != s1_a[WIDTH-1]) &
               (add_op ? (s1_a[WIDTH-1] == sb) : sub_op & (s1_a[WIDTH-1] != sb));
  assign wb = s1_valid & s1_we & ~rsv & (s1_op != OP_CMP);
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      s1_valid  <= 1'b0;
      s1_we     <= 1'b0;
      s1_op     <= '0;
      s1_a      <= '0;
      s1_b      <= '0;
      s1_addr   <= '0;
      out_valid <= 1'b0;
      result    <= '0;
      flags     <= '0;
    end else begin
      s1_valid  <= in_valid;
      s1_we     <= write_en;
      s1_op     <= opcode;
      s1_a      <= a;
      s1_b      <= b;
      s1_addr   <= addr;
      out_valid <= s1_valid;
      if (s1_valid && rsv) result <= '0;
      else if (s1_valid) begin
        if (s1_op != OP_CMP) result <= sum[WIDTH-1:0];
        flags[FLAG_Z] <= sum[WIDTH-1:0] == '0;
        flags[FLAG_C] <= sum[WIDTH];
        flags[FLAG_N] <= sum[WIDTH-1];
        flags[FLAG_V] <= ovf;
      end
    end
  assign zero_flag = flags[FLAG_Z];
  assign carry     = flags[FLAG_C];
  assign neg_flag  = flags[FLAG_N];
  assign ovf_flag  = flags[FLAG_V];
  alu_regfile #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) u_regfile (
    .clk   (clk),
    .rst   (rst),
    .we    (wb),
    .waddr (s1_addr),
    .wdata (sum[WIDTH-1:0]),
    .raddr (rd_addr),
    .rdata (mem_out)
  );
endmodule

// File: tb/tb_alu_pipe_regfile.sv
// tb_alu_pipe_regfile: directed and random ops checked against an integer-arithmetic reference model.
module tb_alu_pipe_regfile;
  logic       clk = 1'b0;
  logic       rst, in_valid, write_en;
  logic [3:0] opcode, addr, rd_addr;
  logic [7:0] a, b, result, mem_out;
  logic       out_valid, zero_flag, carry, neg_flag, ovf_flag;
  int total = 0;
  int bad = 0;
  typedef struct {bit v; int op; int a; int b; bit we; int addr;} op_t;
  op_t pend;
  int m_res, m_z, m_c, m_n, m_v, m_ov, m_mo;
  int m_mem[16];
  always #5 clk = ~clk;
  alu_pipe_regfile #(.WIDTH(8), .ADDR_W(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .opcode(opcode), .a(a), .b(b),
    .write_en(write_en), .addr(addr), .rd_addr(rd_addr), .out_valid(out_valid),
    .result(result), .mem_out(mem_out), .zero_flag(zero_flag), .carry(carry),
    .neg_flag(neg_flag), .ovf_flag(ovf_flag)
  );
  function automatic int sx(input int x);
    return x > 127 ? x - 256 : x;
  endfunction
  function automatic int ovr(input int s);
    return (s > 127 || s < -128) ? 1 : 0;
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic model_reset();
    m_res = 0; m_z = 0; m_c = 0; m_n = 0; m_v = 0; m_ov = 0; m_mo = 0;
    foreach (m_mem[i]) m_mem[i] = 0;
    pend = '{0, 0, 0, 0, 0, 0};
  endtask
  task automatic apply(input op_t p);
    int r, c, v;
    bit rsv;
    r = 0; c = 0; v = 0; rsv = 0;
    case (p.op)
      0:  begin r = p.a + p.b;        v = ovr(sx(p.a) + sx(p.b)); end
      1:  begin r = p.a - p.b;        v = ovr(sx(p.a) - sx(p.b)); end
      2:  begin r = p.a + p.b + m_c;  v = ovr(sx(p.a) + sx(p.b) + m_c); end
      3:  begin r = p.a - p.b - m_c;  v = ovr(sx(p.a) - sx(p.b) - m_c); end
      4:  r = p.a & p.b;
      5:  r = p.a | p.b;
      6:  r = p.a ^ p.b;
      7:  r = 255 - p.a;
      8:  r = p.a * 2;
      9:  r = p.a / 2;
      10: begin r = p.a + 1; v = ovr(sx(p.a) + 1); end
      11: begin r = p.a - 1; v = ovr(sx(p.a) - 1); end
      12: begin r = p.a - p.b; v = ovr(sx(p.a) - sx(p.b)); end
      13: r = p.a;
`ifdef ALU_MUL_EN
      14: r = p.a * p.b;
`endif
      default: rsv = 1;
    endcase
    c = (p.op == 9) ? p.a % 2 : ((r < 0 || r > 255) ? 1 : 0);
    r = r & 255;
    m_ov = 1;
    if (rsv) m_res = 0;
    else begin
      if (p.op != 12) m_res = r;
      m_z = (r == 0); m_c = c; m_n = r / 128; m_v = v;
      if (p.we && p.op != 12) m_mem[p.addr] = r;
    end
  endtask
  task automatic check_all();
    chk("out_valid", out_valid, m_ov);
    chk("result", result, m_res);
    chk("zero", zero_flag, m_z);
    chk("carry", carry, m_c);
    chk("neg", neg_flag, m_n);
    chk("ovf", ovf_flag, m_v);
    chk("mem_out", mem_out, m_mo);
  endtask
  task automatic step(input bit vi, input int op, input int av, input int bv,
                      input bit we, input int ad, input int rd);
    @(negedge clk);
    in_valid = vi; opcode = 4'(op); a = 8'(av); b = 8'(bv);
    write_en = we; addr = 4'(ad); rd_addr = 4'(rd);
    @(posedge clk);
    #1;
    if (pend.v) apply(pend);
    else m_ov = 0;
    m_mo = m_mem[rd];
    pend = '{vi, op, av, bv, we, ad};
    check_all();
  endtask
  task automatic rand_step();
    step($urandom_range(0, 4) != 0, $urandom_range(0, 15), $urandom_range(0, 255),
         $urandom_range(0, 255), $urandom_range(0, 1) == 1, $urandom_range(0, 15),
         $urandom_range(0, 15));
  endtask
  task automatic mid_reset();
    @(negedge clk);
    in_valid = 1; opcode = 4'h0; a = 8'h11; b = 8'h22; write_en = 1; addr = 4'h1;
    #2 rst = 0;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_result", result, 0);
    chk("rst_flags", {zero_flag, carry, neg_flag, ovf_flag}, 0);
    chk("rst_mem_out", mem_out, 0);
    model_reset();
    @(negedge clk);
    in_valid = 0; write_en = 0;
    rst = 1;
  endtask
  initial begin
    rst = 0; in_valid = 0; opcode = 0; a = 0; b = 0; write_en = 0; addr = 0; rd_addr = 0;
    model_reset();
    repeat (2) @(negedge clk);
    check_all();
    rst = 1;
    // reset mid-stream after the regfile has been filled with non-zero data
    for (int i = 0; i < 16; i++) step(1, 13, i + 1, 0, 1, i, 0);
    repeat (20) rand_step();
    mid_reset();
    for (int i = 0; i < 16; i++) step(0, 0, 0, 0, 0, 0, i);
    // ADD wraps to zero with carry
    step(1, 0, 'hFF, 'h01, 1, 3, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    chk("t2_result", result, 'h00);
    chk("t2_carry", carry, 1);
    chk("t2_zero", zero_flag, 1);
    chk("t2_ovf", ovf_flag, 0);
    step(0, 0, 0, 0, 0, 0, 3);
    chk("t2_mem", mem_out, 'h00);
    // signed overflow, then clean subtract
    step(1, 0, 'h7F, 'h01, 0, 0, 0);
    step(1, 1, 'h0B, 'h07, 0, 0, 0);
    chk("t3_add_result", result, 'h80);
    chk("t3_add_flags", {zero_flag, carry, neg_flag, ovf_flag}, 4'b0011);
    step(0, 0, 0, 0, 0, 0, 0);
    chk("t3_sub_result", result, 'h04);
    chk("t3_sub_flags", {zero_flag, carry, neg_flag, ovf_flag}, 4'b0000);
    // back-to-back carry chain
    step(1, 0, 'hF0, 'h20, 0, 0, 0);
    step(1, 2, 'h01, 'h00, 0, 0, 0);
    chk("t4_add_result", result, 'h10);
    chk("t4_add_carry", carry, 1);
    step(0, 0, 0, 0, 0, 0, 0);
    chk("t4_adc_result", result, 'h02);
    chk("t4_adc_carry", carry, 0);
    // CMP keeps result and skips write-back
    step(1, 13, 'h33, 0, 1, 5, 0);
    step(1, 12, 'h05, 'h05, 1, 5, 0);
    step(0, 0, 0, 0, 0, 0, 5);
    chk("t5_result", result, 'h33);
    chk("t5_zero", zero_flag, 1);
    chk("t5_mem", mem_out, 'h33);
    // same-edge write/read bypass
    step(1, 13, 'h5A, 0, 1, 7, 7);
    step(0, 0, 0, 0, 0, 0, 7);
    chk("t6_bypass", mem_out, 'h5A);
    // opcode E and reserved opcode F
    step(1, 14, 'h10, 'h10, 1, 8, 0);
    step(1, 15, 'h44, 'h55, 1, 9, 0);
    chk("t6_mul_result", result, 'h00);
    chk("t6_mul_valid", out_valid, 1);
`ifdef ALU_MUL_EN
    chk("t6_mul_carry", carry, 1);
`else
    chk("t6_mul_carry_hold", carry, 0);
`endif
    step(0, 0, 0, 0, 0, 0, 9);
    chk("t6_rsv_result", result, 'h00);
    chk("t6_rsv_valid", out_valid, 1);
    repeat (400) rand_step();
    mid_reset();
    repeat (40) rand_step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
